biasb_sram_reader: RTL

Read-side controller for the bias SRAM. On a start command it fetches `len` consecutive 512-bit bias words from the SRAM read port, starting at `base_addr`, and streams them to the compute array over a valid/ready interface. A 2-entry output buffer absorbs the SRAM's 1-cycle read latency, so consumer backpressure never drops or duplicates a word. Sits between the bias SRAM's read port and the bias-add stage of the PE array.

---
 rtl/biasb_sram_reader.sv | 113 +++++++++++
 1 files changed

// File: rtl/biasb_sram_reader.sv
// Bias SRAM read controller: fetches len consecutive words from base_addr and
// streams them out over valid/ready, with a 2-entry buffer behind the 1-cycle SRAM latency.
//
// state | meaning
// IDLE  | waiting for start; len=0 commands complete here
// FETCH | issuing reads while buffer credit allows
// DRAIN | all reads issued; delivering remaining words
module biasb_sram_reader #(
  parameter int AW = 7,
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          sram_enb,
  output logic [AW-1:0] sram_addrb,
  input  logic [DW-1:0] sram_doutb,
  output logic          bias_valid,
  input  logic          bias_ready,
  output logic [DW-1:0] bias_data
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   iss_q, del_q;
  logic [1:0]    occ_q;
  logic          inflight_q;
  logic [DW-1:0] mem_q [2];
  logic          rd_q, wr_q;
  logic          zl_done_q;

  logic          issue, pop, bypass, buf_wr, buf_rd, done_c, accept;
  logic [2:0]    used;

  // A returning word with an empty buffer is presented directly, so the
  // consumer sees it in the same cycle it arrives from the SRAM.
  assign bypass     = (occ_q == 2'd0) && inflight_q;
  assign bias_valid = (occ_q != 2'd0) || inflight_q;
  assign bias_data  = bypass ? sram_doutb : mem_q[rd_q];
  assign pop        = bias_valid && bias_ready;

  assign used   = {1'b0, occ_q} + {2'b0, inflight_q};
  assign issue  = (state_q == FETCH) && (iss_q != '0) &&
                  ((used < 3'd2) || (pop && (used == 3'd2)));
  assign buf_wr = inflight_q && !(bypass && pop);
  assign buf_rd = pop && !bypass;
  assign accept = (state_q == IDLE) && start;

  assign sram_enb   = issue;
  assign sram_addrb = ptr_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_c || zl_done_q;

  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE:  if (start && (len != '0)) state_d = FETCH;
      FETCH: if (issue && (iss_q == (AW+1)'(1))) state_d = DRAIN;
      DRAIN: begin
        if (pop && (del_q == (AW+1)'(1))) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      iss_q      <= '0;
      del_q      <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      zl_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      zl_done_q  <= accept && (len == '0);
      if (accept && (len != '0)) begin
        ptr_q <= base_addr;
        iss_q <= len;
        del_q <= len;
      end else begin
        if (issue) begin
          ptr_q <= ptr_q + AW'(1);
          iss_q <= iss_q - (AW+1)'(1);
        end
        if (pop) del_q <= del_q - (AW+1)'(1);
      end
      if (buf_wr) begin
        mem_q[wr_q] <= sram_doutb;
        wr_q        <= ~wr_q;
      end
      if (buf_rd) rd_q <= ~rd_q;
      occ_q <= occ_q + {1'b0, buf_wr} - {1'b0, buf_rd};
    end
  end

endmodule
